div_sfx_ufx_seq: RTL and testbench

//  Iterative divider: signed 32-bit fixed-point value divided by unsigned 8-bit

---
 rtl/div_sfx_ufx_seq.sv | 111 +++++++++++
 tb/tb_div_sfx_ufx_seq.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/div_sfx_ufx_seq.sv
// Signed 32-bit fixed-point / unsigned 8-bit radix-2 restoring divider, one quotient bit per clock.
// Latency 33 clocks start-to-done (1 for divide-by-zero); start is ignored while busy, nothing is queued.
module div_sfx_ufx_seq #(
  parameter int SW = 32,
  parameter int UW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [SW-1:0] sdata,
  input  logic [UW-1:0] udata,
  output logic          busy,
  output logic          done,
  output logic [SW-1:0] result,
  output logic [UW:0]   remainder,
  output logic          div_zero
);

  localparam int CW = $clog2(SW + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_neg;
  logic          r_dz;
  logic [SW-1:0] r_mag;
  logic [UW-1:0] r_div;
  logic [UW-1:0] r_part;
  logic [CW-1:0] r_cnt;
  logic [SW-1:0] r_result;
  logic [UW:0]   r_rem;
  logic          r_div_zero;

  logic [UW:0]   w_shift;
  logic          w_ge;
  logic [UW-1:0] w_diff;
  logic          w_last;

  // Partial remainder stays below the divisor, so UW bits hold it between steps.
  assign w_shift = {r_part, r_mag[SW-1]};
  assign w_ge    = (w_shift >= {1'b0, r_div});
  assign w_diff  = w_shift[UW-1:0] - r_div;
  assign w_last  = (r_cnt == CW'(SW));

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_CALC;
      S_CALC:  if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
    done = (r_state == S_DONE);
  end

  // Divide-by-zero preloads the count so the next edge publishes straight away.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_neg      <= 1'b0;
      r_dz       <= 1'b0;
      r_mag      <= '0;
      r_div      <= '0;
      r_part     <= '0;
      r_cnt      <= '0;
      r_result   <= '0;
      r_rem      <= '0;
      r_div_zero <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_neg  <= sdata[SW-1];
          r_mag  <= sdata[SW-1] ? -sdata : sdata;
          r_div  <= udata;
          r_part <= '0;
          r_dz   <= (udata == '0);
          r_cnt  <= (udata == '0) ? CW'(SW) : '0;
        end
        S_CALC: if (w_last) begin
          r_div_zero <= r_dz;
          if (r_dz) begin
            r_result <= r_neg ? {1'b1, {(SW-1){1'b0}}} : {1'b0, {(SW-1){1'b1}}};
            r_rem    <= '0;
          end else begin
            r_result <= r_neg ? -r_mag : r_mag;
            r_rem    <= r_neg ? -{1'b0, r_part} : {1'b0, r_part};
          end
        end else begin
          r_part <= w_ge ? w_diff : w_shift[UW-1:0];
          r_mag  <= {r_mag[SW-2:0], w_ge};
          r_cnt  <= r_cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign result    = r_result;
  assign remainder = r_rem;
  assign div_zero  = r_div_zero;

endmodule

// File: tb/tb_div_sfx_ufx_seq.sv
// Directed + random bench for div_sfx_ufx_seq; expectations queued at issue, checked at done.
module tb_div_sfx_ufx_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] sdata = '0;
  logic [7:0]  udata = '0;
  logic        busy, done, div_zero;
  logic [31:0] result;
  logic [8:0]  remainder;

  always #5 clk = ~clk;

  div_sfx_ufx_seq #(.SW(32), .UW(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sdata(sdata), .udata(udata),
    .busy(busy), .done(done), .result(result), .remainder(remainder), .div_zero(div_zero)
  );

  typedef struct {
    logic [31:0] res;
    logic [8:0]  rem;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] res, input logic [8:0] rem, input logic dz, input int lat);
    exp_t e;
    e.res = res; e.rem = rem; e.dz = dz; e.lat = lat;
    return e;
  endfunction

  // Reference built on the simulator's own signed arithmetic (truncating division).
  function automatic exp_t model(input logic [31:0] sd, input logic [7:0] ud);
    longint s, q, r;
    s = longint'($signed(sd));
    if (ud == 8'd0) return mk(sd[31] ? 32'h8000_0000 : 32'h7FFF_FFFF, 9'd0, 1'b1, 1);
    q = s / longint'(ud);
    r = s % longint'(ud);
    return mk(q[31:0], r[8:0], 1'b0, 33);
  endfunction

  task automatic issue(input logic [31:0] sd, input logic [7:0] ud, input exp_t e);
    @(negedge clk);
    start = 1'b1; sdata = sd; udata = ud;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0; sdata = $urandom; udata = 8'($urandom);
  endtask

  // Waits (bounded) for done, pulsing start at cycles p1/p2 of the operation.
  task automatic run(input string tag, input int p1, input int p2);
    int   cyc = 0;
    bit   busy_ok = 1'b1;
    exp_t e;
    forever begin
      start = (cyc == p1 || cyc == p2);
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (done === 1'b1 || cyc >= 60) break;
      @(negedge clk);
      cyc++;
    end
    check($sformatf("%s.done_seen", tag), {63'd0, done}, 64'd1);
    check($sformatf("%s.sb_depth", tag), 64'(sb.size()), 64'd1);
    e = (sb.size() > 0) ? sb.pop_front() : mk('0, '0, 1'b0, -1);
    check($sformatf("%s.latency", tag), 64'(cyc), 64'(e.lat));
    check($sformatf("%s.result", tag), {32'd0, result}, {32'd0, e.res});
    check($sformatf("%s.remainder", tag), {55'd0, remainder}, {55'd0, e.rem});
    check($sformatf("%s.div_zero", tag), {63'd0, div_zero}, {63'd0, e.dz});
    check($sformatf("%s.busy_profile", tag), {63'd0, busy_ok}, 64'd1);
    @(negedge clk);
    start = 1'b0;
    check($sformatf("%s.idle_after", tag), {62'd0, busy, done}, 64'd0);
    check($sformatf("%s.held", tag), {32'd0, result}, {32'd0, e.res});
  endtask

  initial begin
    int          nd;
    logic [31:0] rsd;
    logic [7:0]  rud;

    repeat (3) @(negedge clk);
    check("reset.flags", {61'd0, busy, done, div_zero}, 64'd0);
    check("reset.result", {32'd0, result}, 64'd0);
    check("reset.remainder", {55'd0, remainder}, 64'd0);
    rst_n = 1'b1;

    issue(32'd1000, 8'd7, mk(32'd142, 9'd6, 1'b0, 33));
    run("pos_1000_7", -1, -1);
    issue(-32'sd1000, 8'd7, mk(32'hFFFF_FF72, 9'h1FA, 1'b0, 33));
    run("neg_1000_7", -1, -1);
    issue(32'h8000_0000, 8'd1, mk(32'h8000_0000, 9'd0, 1'b0, 33));
    run("min_div1", -1, -1);
    issue(32'h8000_0000, 8'd255, mk(32'hFF7F_7F80, 9'h180, 1'b0, 33));
    run("min_div255", -1, -1);
    issue(32'd5, 8'd0, mk(32'h7FFF_FFFF, 9'd0, 1'b1, 1));
    run("dz_pos", -1, -1);
    issue(-32'sd5, 8'd0, mk(32'h8000_0000, 9'd0, 1'b1, 1));
    run("dz_neg", -1, -1);

    issue(32'd1000, 8'd7, mk(32'd142, 9'd6, 1'b0, 33));
    run("ignored_start", 5, 33);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    check("ignored_start.no_extra_done", 64'(nd), 64'd0);

    issue(32'd1234, 8'd9, model(32'd1234, 8'd9));
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    check("midreset.flags", {61'd0, busy, done, div_zero}, 64'd0);
    check("midreset.result", {32'd0, result}, 64'd0);
    check("midreset.remainder", {55'd0, remainder}, 64'd0);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
    end
    check("midreset.no_done", 64'(nd), 64'd0);
    issue(32'd1234, 8'd9, model(32'd1234, 8'd9));
    run("after_reset", -1, -1);

    for (int i = 0; i < 6; i++) begin
      rsd = $urandom;
      rud = 8'($urandom_range(1, 255));
      issue(rsd, rud, model(rsd, rud));
      run($sformatf("rand%0d", i), -1, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
